// File: rtl/pixel_stream_tagger.sv
// Consumes raster counter coordinates under backpressure and tags each with its linear
// address and sof/eol/eof. Beats leave through a 2-entry skid FIFO with valid/ready.
module pixel_stream_tagger #(
    parameter int WIDTH       = 32,
    parameter int HEIGHT      = 32,
    parameter int FRAME_CNT_W = 16,
    localparam int CW = $clog2(WIDTH),
    localparam int RW = $clog2(HEIGHT),
    localparam int AW = $clog2(WIDTH * HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [CW-1:0]          col_in,
    input  logic [RW-1:0]          row_in,
    output logic                   cnt_enable,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [CW-1:0]          m_col,
    output logic [RW-1:0]          m_row,
    output logic [AW-1:0]          m_addr,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   m_eof,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   seq_err,
    output logic                   busy
);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef struct packed {
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic [AW-1:0] addr;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    // Tags are resolved at capture so the FIFO carries a complete beat.
    function automatic beat_t tag_beat(input logic [RW-1:0] r, input logic [CW-1:0] c);
        beat_t b;
        b.col  = c;
        b.row  = r;
        b.addr = AW'(r) * AW'(WIDTH) + AW'(c);
        b.sof  = (r == '0) && (c == '0);
        b.eol  = (c == COL_LAST);
        b.eof  = (r == ROW_LAST) && (c == COL_LAST);
        return b;
    endfunction

    function automatic logic [RW+CW-1:0] raster_next(input logic [RW-1:0] r,
                                                     input logic [CW-1:0] c);
        if (c == COL_LAST) begin
            if (r == ROW_LAST) begin
                return '0;
            end
            return {RW'(r + 1'b1), {CW{1'b0}}};
        end
        return {r, CW'(c + 1'b1)};
    endfunction

    state_t                 state_q;
    logic [1:0]             occ_q, occ_d;
    beat_t                  head_q, head_d;
    beat_t                  tail_q, tail_d;
    logic [CW-1:0]          exp_col_q;
    logic [RW-1:0]          exp_row_q;
    logic                   seq_err_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    beat_t cap_beat;
    logic  push;
    logic  pop;

    // Enable depends only on registered state, so m_ready never reaches the counter.
    assign push     = (state_q != IDLE) && (occ_q != 2'd2);
    assign pop      = (occ_q != 2'd0) && m_ready;
    assign cap_beat = tag_beat(row_in, col_in);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = cap_beat;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = cap_beat;
                end else if (push) begin
                    tail_d = cap_beat;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= 2'd0;
            head_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_col_q   <= '0;
            exp_row_q   <= '0;
            seq_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE:    if (run) state_q <= STREAM;
                STREAM:  if (!run) state_q <= FINISH;
                FINISH:  if (push && cap_beat.eof) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (push) begin
                if ({row_in, col_in} != {exp_row_q, exp_col_q}) begin
                    seq_err_q <= 1'b1;
                end
                {exp_row_q, exp_col_q} <= raster_next(row_in, col_in);
            end
            if (pop && head_q.eof) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign cnt_enable  = push;
    assign m_valid     = (occ_q != 2'd0);
    assign m_col       = head_q.col;
    assign m_row       = head_q.row;
    assign m_addr      = head_q.addr;
    assign m_sof       = head_q.sof;
    assign m_eol       = head_q.eol;
    assign m_eof       = head_q.eof;
    assign frame_count = frame_cnt_q;
    assign seq_err     = seq_err_q;
    assign busy        = (state_q != IDLE) || (occ_q != 2'd0);

endmodule

// File: tb/tb_pixel_stream_tagger.sv
// Bench for pixel_stream_tagger: raster counter stand-in, queue-based reference model,
// directed table checks on the handed-off beat log and hand-written corner sequences.
`timescale 1ns/1ps
module tb_pixel_stream_tagger;
    localparam int W = 32;
    localparam int H = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        m_ready = 1'b1;
    logic [4:0]  col_in, row_in;
    logic        cnt_enable, m_valid, m_sof, m_eol, m_eof, seq_err, busy;
    logic [4:0]  m_col, m_row;
    logic [9:0]  m_addr;
    logic [15:0] frame_count;

    logic [4:0]  ctr_col = '0, ctr_row = '0;
    logic        ovr = 1'b0;
    logic [4:0]  ovr_col = '0;

    assign col_in = ovr ? ovr_col : ctr_col;
    assign row_in = ctr_row;

    always #5 clk = ~clk;

    pixel_stream_tagger #(.WIDTH(W), .HEIGHT(H), .FRAME_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .col_in(col_in), .row_in(row_in),
        .cnt_enable(cnt_enable), .m_valid(m_valid), .m_ready(m_ready),
        .m_col(m_col), .m_row(m_row), .m_addr(m_addr),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .frame_count(frame_count), .seq_err(seq_err), .busy(busy)
    );

    // Raster counter the block is meant to drive.
    always @(posedge clk) begin
        if (rst) begin
            ctr_col <= '0;
            ctr_row <= '0;
        end else if (cnt_enable) begin
            if (ctr_col == 5'(W - 1)) begin
                ctr_col <= '0;
                ctr_row <= (ctr_row == 5'(H - 1)) ? 5'd0 : ctr_row + 5'd1;
            end else begin
                ctr_col <= ctr_col + 5'd1;
            end
        end
    end

    typedef struct packed {
        logic [4:0] row;
        logic [4:0] col;
        logic [9:0] addr;
        logic       sof;
        logic       eol;
        logic       eof;
    } tbeat_t;

    function automatic tbeat_t mk(input int r, input int c);
        tbeat_t b;
        b.row  = 5'(r);
        b.col  = 5'(c);
        b.addr = 10'(r * W + c);
        b.sof  = (r == 0 && c == 0);
        b.eol  = (c == W - 1);
        b.eof  = (r == H - 1 && c == W - 1);
        return b;
    endfunction

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: list of buffered beats, a mode (0 idle, 1 streaming, 2 finishing),
    // the linear index expected next, and the handed-off frame count.
    tbeat_t mq[$];
    int     md_mode = 0;
    int     md_fc = 0;
    bit     md_serr = 1'b0;
    int     md_exp = 0;
    bit     md_en;
    int     md_idx;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            md_mode = 0;
            md_fc   = 0;
            md_serr = 1'b0;
            md_exp  = 0;
        end else begin
            md_en  = (md_mode != 0) && (mq.size() < 2);
            md_idx = int'(row_in) * W + int'(col_in);
            if (mq.size() > 0 && m_ready) begin
                if (mq[0].eof) md_fc = (md_fc + 1) % 65536;
                void'(mq.pop_front());
            end
            if (md_en) begin
                if (md_idx != md_exp) md_serr = 1'b1;
                md_exp = (md_idx + 1) % (W * H);
                mq.push_back(mk(int'(row_in), int'(col_in)));
            end
            case (md_mode)
                0:       if (run) md_mode = 1;
                1:       if (!run) md_mode = 2;
                default: if (md_en && md_idx == W * H - 1) md_mode = 0;
            endcase
        end
    end

    tbeat_t log_q[$];
    always @(posedge clk) begin
        if (!rst && m_valid && m_ready) begin
            log_q.push_back({m_row, m_col, m_addr, m_sof, m_eol, m_eof});
        end
    end

    bit          chk_on = 1'b0;
    logic [42:0] cyc_got, cyc_exp;
    always @(negedge clk) begin
        if (chk_on) begin
            cyc_got = {m_valid, cnt_enable, busy, seq_err, frame_count,
                       m_valid ? tbeat_t'({m_row, m_col, m_addr, m_sof, m_eol, m_eof}) : 23'd0};
            cyc_exp = {mq.size() != 0, (md_mode != 0) && (mq.size() < 2),
                       (md_mode != 0) || (mq.size() != 0), md_serr, 16'(md_fc),
                       (mq.size() != 0) ? mq[0] : 23'd0};
            check("cycle_model", 64'(cyc_got), 64'(cyc_exp));
        end
    end

    typedef struct {
        int idx;
        int row;
        int col;
        int addr;
        bit sof;
        bit eol;
        bit eof;
    } vec_t;

    vec_t   vecs[10];
    tbeat_t want;
    int     n0;
    int     guard;
    bit     found;

    initial begin
        vecs[0] = '{0,    0,  0,  0,    1'b1, 1'b0, 1'b0};
        vecs[1] = '{1,    0,  1,  1,    1'b0, 1'b0, 1'b0};
        vecs[2] = '{31,   0,  31, 31,   1'b0, 1'b1, 1'b0};
        vecs[3] = '{32,   1,  0,  32,   1'b0, 1'b0, 1'b0};
        vecs[4] = '{100,  3,  4,  100,  1'b0, 1'b0, 1'b0};
        vecs[5] = '{511,  15, 31, 511,  1'b0, 1'b1, 1'b0};
        vecs[6] = '{1023, 31, 31, 1023, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1024, 0,  0,  0,    1'b1, 1'b0, 1'b0};
        vecs[8] = '{2047, 31, 31, 1023, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{2048, 0,  0,  0,    1'b1, 1'b0, 1'b0};

        // Reset for two edges, then start streaming with a free-running sink.
        rst = 1'b1; run = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_data", 64'({m_row, m_col, m_addr, m_sof, m_eol, m_eof}), 64'd0);
        check("rst_cnt_enable", 64'(cnt_enable), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_seq_err", 64'(seq_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        chk_on = 1'b1;
        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);
        check("start_cnt_enable", 64'(cnt_enable), 64'd1);
        check("start_no_beat", 64'(m_valid), 64'd0);
        @(negedge clk);
        check("first_beat", 64'({m_valid, m_row, m_col, m_addr, m_sof}),
              64'({1'b1, 5'd0, 5'd0, 10'd0, 1'b1}));

        guard = 0;
        while (log_q.size() < 2049 && guard < 2300) begin
            @(negedge clk);
            guard++;
        end
        check("two_frames_timeout", 64'(log_q.size() >= 2049), 64'd1);
        for (int i = 0; i < 10; i++) begin
            want = {5'(vecs[i].row), 5'(vecs[i].col), 10'(vecs[i].addr),
                    vecs[i].sof, vecs[i].eol, vecs[i].eof};
            if (vecs[i].idx < log_q.size())
                check($sformatf("beat_%0d", vecs[i].idx), 64'(log_q[vecs[i].idx]), 64'(want));
            else
                check($sformatf("beat_%0d_missing", vecs[i].idx), 64'd0, 64'd1);
        end
        check("frame_count_2", 64'(frame_count), 64'd2);

        // Stall the sink with (3,5) at the head.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (m_valid && m_row == 5'd3 && m_col == 5'd5) found = 1'b1;
        end
        check("stall_head_found", 64'(found), 64'd1);
        m_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_cnt_enable", 64'(cnt_enable), 64'd0);
        check("stall_hold", 64'({m_valid, m_row, m_col}), 64'({1'b1, 5'd3, 5'd5}));
        n0 = log_q.size();
        m_ready = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (n0 + k < log_q.size())
                check($sformatf("resume_%0d", k), 64'(log_q[n0 + k]), 64'(mk(3, 5 + k)));
            else
                check($sformatf("resume_%0d_missing", k), 64'd0, 64'd1);
        end
        check("stall_seq_err", 64'(seq_err), 64'd0);

        // Random sink pressure with occasional run toggles.
        repeat (3000) begin
            @(negedge clk);
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) run = ~run;
        end

        // Stop request right after (5,7) is captured.
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            m_ready = ($urandom_range(0, 3) != 0);
            if (cnt_enable && row_in == 5'd5 && col_in == 5'd7) found = 1'b1;
        end
        check("stop_point_found", 64'(found), 64'd1);
        @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            m_ready = ($urandom_range(0, 3) != 0);
            if (!busy) found = 1'b1;
        end
        check("stop_drained", 64'(found), 64'd1);
        check("stop_cnt_enable", 64'(cnt_enable), 64'd0);
        check("stop_m_valid", 64'(m_valid), 64'd0);
        if (log_q.size() > 0)
            check("stop_last_beat", 64'(log_q[log_q.size() - 1]), 64'(mk(31, 31)));
        else
            check("stop_last_beat_missing", 64'd0, 64'd1);
        check("stop_counter_home", 64'({ctr_row, ctr_col}), 64'd0);
        repeat (5) @(negedge clk);
        check("stop_stays_idle", 64'({busy, cnt_enable}), 64'd0);

        // Skip from column 9 to 12.
        rst = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (cnt_enable && col_in == 5'd9) found = 1'b1;
        end
        check("skip_point_found", 64'(found), 64'd1);
        check("skip_seq_err_before", 64'(seq_err), 64'd0);
        @(negedge clk);
        ovr = 1'b1;
        ovr_col = 5'd12;
        @(negedge clk);
        ovr = 1'b0;
        check("skip_seq_err_set", 64'(seq_err), 64'd1);
        repeat (1100) @(negedge clk);
        check("skip_seq_err_sticky", 64'(seq_err), 64'd1);
        check("skip_frame_count", 64'(frame_count), 64'd1);

        // Reset with two beats buffered.
        m_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!cnt_enable) found = 1'b1;
        end
        check("full_reached", 64'({found, m_valid, busy}), 64'({1'b1, 1'b1, 1'b1}));
        rst = 1'b1;
        @(negedge clk);
        check("flush_m_valid", 64'(m_valid), 64'd0);
        check("flush_frame_count", 64'(frame_count), 64'd0);
        check("flush_cnt_enable", 64'(cnt_enable), 64'd0);
        check("flush_seq_err", 64'(seq_err), 64'd0);
        check("flush_data", 64'({busy, m_addr}), 64'd0);
        rst = 1'b0;
        run = 1'b0;
        m_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
